axis_i2c_cmd_seq: RTL

//  Upstream command sequencer for the AXIS I2C master path. Holds a small table of I2C

---
 rtl/axis_i2c_pkg.sv | 17 +
 rtl/seq_cmd_ram.sv | 24 ++
 rtl/axis_i2c_cmd_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/axis_i2c_pkg.sv
// axis_i2c_pkg: shared types and defaults for the I2C command sequencer
package axis_i2c_pkg;

    localparam int DEF_AXIS_DATA_WIDTH = 24;
    localparam int DEF_SEQ_DEPTH       = 16;
    localparam int DEF_GAP_CYCLES      = 1000;

    typedef struct packed {
        logic [6:0] dev_addr;
        logic       rw;
        logic [7:0] reg_addr;
        logic [7:0] wdata;
    } i2c_cmd_t;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, DONE} seq_state_t;

endpackage

// File: rtl/seq_cmd_ram.sv
// seq_cmd_ram: simple dual-port command table, one write port, one registered read port
module seq_cmd_ram #(
    parameter  int W     = 24,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem [DEPTH];

    // table write and synchronous read; contents deliberately not reset
    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/axis_i2c_cmd_seq.sv
// axis_i2c_cmd_seq: replays a host-loaded command table as an AXIS stream with idle gaps
module axis_i2c_cmd_seq
    import axis_i2c_pkg::*;
#(
    parameter  int AXIS_DATA_WIDTH = DEF_AXIS_DATA_WIDTH,
    parameter  int SEQ_DEPTH       = DEF_SEQ_DEPTH,
    parameter  int GAP_CYCLES      = DEF_GAP_CYCLES,
    localparam int IDX_W           = $clog2(SEQ_DEPTH)
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic                       cfg_we_i,
    input  logic [IDX_W-1:0]           cfg_addr_i,
    input  logic [AXIS_DATA_WIDTH-1:0] cfg_wdata_i,
    output logic                       cfg_err_o,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [IDX_W:0]             num_cmds_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [IDX_W-1:0]           cmd_idx_o,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(SEQ_DEPTH);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    seq_state_t state, state_nx;
    logic [IDX_W-1:0] idx, idx_nx, last, last_nx;
    logic [GW-1:0] gap, gap_nx;
    logic [IDX_W:0] num_c;
    logic [AXIS_DATA_WIDTH-1:0] rdata;
    logic abort_q, done_q, err_q, idle, hs, abort_p;

    // done_o is registered, so the sequencer stays busy until its pulse has been seen
    assign idle          = state == IDLE && !done_q;
    assign hs            = m_axis_tvalid && m_axis_tready;
    assign abort_p       = abort_q || abort_i;
    assign num_c         = num_cmds_i > DEPTH_C ? DEPTH_C : num_cmds_i;
    assign busy_o        = !idle;
    assign done_o        = done_q;
    assign cfg_err_o     = err_q;
    assign cmd_idx_o     = idx;
    assign m_axis_tvalid = state == SEND;
    assign m_axis_tdata  = m_axis_tvalid ? rdata : '0;

    seq_cmd_ram #(.W(AXIS_DATA_WIDTH), .DEPTH(SEQ_DEPTH)) u_ram (
        .clk_i   (clk_i),
        .we_i    (cfg_we_i && idle),
        .waddr_i (cfg_addr_i),
        .wdata_i (cfg_wdata_i),
        .re_i    (state == LOAD),
        .raddr_i (idx),
        .rdata_o (rdata)
    );

    // next-state logic: walk the table, idling GAP_CYCLES after each accepted beat
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        last_nx  = last;
        gap_nx   = gap;
        case (state)
            IDLE: if (start_i && idle) begin
                state_nx = num_c != '0 ? LOAD : DONE;
                idx_nx   = '0;
                last_nx  = IDX_W'(num_c - 1'b1);
            end
            LOAD: state_nx = abort_p ? DONE : SEND;
            SEND: if (hs) begin
                if (idx == last || abort_p) state_nx = DONE;
                else if (GAP_CYCLES == 0) begin
                    state_nx = LOAD;
                    idx_nx   = idx + 1'b1;
                end else begin
                    state_nx = GAP;
                    gap_nx   = GAP_LOAD;
                end
            end
            GAP: if (abort_p) state_nx = DONE;
                else if (gap == '0) begin
                    state_nx = LOAD;
                    idx_nx   = idx + 1'b1;
                end else gap_nx = gap - 1'b1;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state, counters, sticky abort and status pulses
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state   <= IDLE;
            idx     <= '0;
            last    <= '0;
            gap     <= '0;
            abort_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            last    <= last_nx;
            gap     <= gap_nx;
            abort_q <= state == DONE ? 1'b0 : abort_q || (abort_i && state != IDLE);
            done_q  <= state == DONE;
            err_q   <= cfg_we_i && !idle;
        end
    end

endmodule
